// File: rtl/latch_edge_monitor.sv
// Synchronizes and debounces a latch output, emits one-cycle rise/fall pulses
// and keeps a saturating count of accepted edges.
//
// state   | meaning
// ST_LO   | filtered level low, waiting for a synchronized high
// PEND_HI | high seen, qualifying for STABLE_CNT consecutive samples
// ST_HI   | filtered level high, waiting for a synchronized low
// PEND_LO | low seen, qualifying for STABLE_CNT consecutive samples
module latch_edge_monitor #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             clr,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             sat
);

  typedef enum logic [1:0] {
    ST_LO   = 2'b00,
    PEND_HI = 2'b01,
    ST_HI   = 2'b11,
    PEND_LO = 2'b10
  } state_t;

  localparam logic [7:0]       STAB_LAST = 8'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state_q, state_d;
  logic [7:0] stab_q, stab_d;
  logic       s1, s2;
  logic       q_filt_d, rise_d, fall_d;
  logic       accept;

  // Two-flop synchronizer: the only place d_in is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      stab_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      ST_LO: begin
        if (s2) begin
          state_d = PEND_HI;
          stab_d  = 8'd1;
        end else begin
          stab_d  = 8'd0;
        end
      end
      PEND_HI: begin
        if (!s2) begin
          state_d = ST_LO;
          stab_d  = 8'd0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_HI;
          stab_d  = 8'd0;
        end else begin
          stab_d  = stab_q + 8'd1;
        end
      end
      ST_HI: begin
        if (!s2) begin
          state_d = PEND_LO;
          stab_d  = 8'd1;
        end else begin
          stab_d  = 8'd0;
        end
      end
      PEND_LO: begin
        if (s2) begin
          state_d = ST_HI;
          stab_d  = 8'd0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_LO;
          stab_d  = 8'd0;
        end else begin
          stab_d  = stab_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_LO;
        stab_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    rise_d   = (state_q == PEND_HI) && s2  && (stab_q == STAB_LAST);
    fall_d   = (state_q == PEND_LO) && !s2 && (stab_q == STAB_LAST);
    q_filt_d = (state_d == ST_HI) || (state_d == PEND_LO);
  end

  assign accept = rise_d | fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_filt <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      q_filt <= q_filt_d;
      rise   <= rise_d;
      fall   <= fall_d;
    end
  end

  // Clear wins over saturation; an edge in the clear cycle is counted afresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (clr) begin
      edge_cnt <= accept ? CNT_ONE : '0;
      sat      <= 1'b0;
    end else if (accept && (edge_cnt != CNT_MAX)) begin
      edge_cnt <= edge_cnt + CNT_ONE;
      if (edge_cnt == (CNT_MAX - CNT_ONE)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Self-checking bench for latch_edge_monitor: directed sequences, a pulse-length
// vector table and random mid-cycle stimulus against a sample-window model.
module tb_latch_edge_monitor;

  localparam int STABLE = 4;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_in;
  logic          clr;
  logic          q_filt, rise, fall, sat;
  logic [CW-1:0] edge_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  latch_edge_monitor #(.STABLE_CNT(STABLE), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_in     (d_in),
    .clr      (clr),
    .q_filt   (q_filt),
    .rise     (rise),
    .fall     (fall),
    .edge_cnt (edge_cnt),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the filtered level flips once the last STABLE synchronized
  // samples all disagree with it.
  bit       m_s1, m_s2, m_q, m_rise, m_fall, m_sat;
  bit [7:0] m_cnt;
  bit       hist[$];

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    bit all_flip;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_q = 0; m_rise = 0; m_fall = 0;
      m_cnt = 0; m_sat = 0;
      hist.delete();
    end else begin
      acc = 0;
      hist.push_back(m_s2);
      if (hist.size() > STABLE) void'(hist.pop_front());
      all_flip = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] == m_q) all_flip = 0;
      m_rise = 0;
      m_fall = 0;
      if (all_flip) begin
        m_q = ~m_q;
        if (m_q) m_rise = 1; else m_fall = 1;
        acc = 1;
      end
      if (clr) begin
        m_cnt = acc ? 8'd1 : 8'd0;
        m_sat = 0;
      end else if (acc && m_cnt != 8'hFF) begin
        m_cnt = m_cnt + 8'd1;
        if (m_cnt == 8'hFF) m_sat = 1;
      end
      m_s2 = m_s1;
      m_s1 = d_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("m_q_filt", int'(q_filt), int'(m_q));
      chk("m_rise", int'(rise), int'(m_rise));
      chk("m_fall", int'(fall), int'(m_fall));
      chk("m_edge_cnt", int'(edge_cnt), int'(m_cnt));
      chk("m_sat", int'(sat), int'(m_sat));
      chk("rise_fall_excl", int'(rise & fall), 0);
    end
  end

  typedef struct {
    int hi_len;
    int exp_edges;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nr;
    int dly;
    vecs[0] = '{1, 0};
    vecs[1] = '{2, 0};
    vecs[2] = '{3, 0};
    vecs[3] = '{5, 2};
    vecs[4] = '{8, 2};
    vecs[5] = '{20, 2};

    rst_n = 0; d_in = 0; clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_q_filt", int'(q_filt), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_edge_cnt", int'(edge_cnt), 0);
    chk("rst_sat", int'(sat), 0);
    rst_n = 1;
    mon_en = 1;
    repeat (3) @(negedge clk);

    // First rise: visible after the 6th edge, one-cycle pulse.
    d_in = 1;
    repeat (5) @(negedge clk);
    chk("lat_q_early", int'(q_filt), 0);
    chk("lat_rise_early", int'(rise), 0);
    @(negedge clk);
    chk("lat_q", int'(q_filt), 1);
    chk("lat_rise", int'(rise), 1);
    chk("lat_cnt", int'(edge_cnt), 1);
    chk("lat_fall", int'(fall), 0);
    @(negedge clk);
    chk("lat_rise_end", int'(rise), 0);
    chk("lat_q_hold", int'(q_filt), 1);
    d_in = 0;
    repeat (10) @(negedge clk);
    chk("first_fall_cnt", int'(edge_cnt), 2);

    // Pulse-length table: glitches rejected, qualified pulses give rise+fall.
    foreach (vecs[v]) begin
      clr = 1;
      @(negedge clk);
      clr = 0;
      nr = 0;
      d_in = 1;
      for (int c = 0; c < vecs[v].hi_len + 14; c++) begin
        if (c == vecs[v].hi_len) d_in = 0;
        @(negedge clk);
        nr += int'(rise);
      end
      chk($sformatf("vec%0d_rises", v), nr, vecs[v].exp_edges / 2);
      chk($sformatf("vec%0d_cnt", v), int'(edge_cnt), vecs[v].exp_edges);
      chk($sformatf("vec%0d_q", v), int'(q_filt), 0);
    end

    // Reset while qualifying a rise aborts it; full requalification follows.
    d_in = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("prst_q", int'(q_filt), 0);
    chk("prst_rise", int'(rise), 0);
    chk("prst_fall", int'(fall), 0);
    chk("prst_cnt", int'(edge_cnt), 0);
    chk("prst_sat", int'(sat), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("prst_q_early", int'(q_filt), 0);
    @(negedge clk);
    chk("prst_q_late", int'(q_filt), 1);
    chk("prst_rise_late", int'(rise), 1);
    chk("prst_cnt_late", int'(edge_cnt), 1);

    // Saturation.
    d_in = 0;
    repeat (10) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    for (int i = 0; i < 255; i++) begin
      d_in = ~d_in;
      repeat (10) @(negedge clk);
    end
    chk("sat_cnt", int'(edge_cnt), 255);
    chk("sat_flag", int'(sat), 1);
    d_in = ~d_in;
    repeat (10) @(negedge clk);
    chk("sat_hold_cnt", int'(edge_cnt), 255);
    chk("sat_hold_flag", int'(sat), 1);
    chk("sat_q_low", int'(q_filt), 0);

    // Clear coinciding with an accepted rise.
    d_in = 1;
    repeat (5) @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_edge_cnt", int'(edge_cnt), 1);
    chk("clr_edge_sat", int'(sat), 0);
    chk("clr_edge_rise", int'(rise), 1);
    chk("clr_edge_q", int'(q_filt), 1);
    repeat (10) @(negedge clk);

    // Random mid-cycle changes of d_in and clr.
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(1, 12)) @(posedge clk);
      dly = $urandom_range(1, 9);
      #(dly);
      d_in = 1'($urandom);
      clr = ($urandom_range(0, 7) == 0);
    end
    clr = 0;
    repeat (20) @(negedge clk);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
